// File: rtl/fib_07_top.sv
// rtl/fib_07_top.sv - selector-gated Fibonacci generator with wrapping run bound
//
// Steps the pair (a,b) = (F(i), F(i+1)) once per cycle while selector is high.
// When i reaches the bound n the block parks in DONE. The next enabled cycle
// restarts the sequence with bound n+1. A restart from n==N_MAX reloads N_INIT.
//
// Optional feature macro: FIB_SAT_EN
//   defined   : b saturates at 2^WIDTH-1 instead of wrapping
//   undefined : plain modulo-2^WIDTH addition
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous active-low reset
//   selector in   1      step enable
//   a        out  WIDTH  F(i)
//   b        out  WIDTH  F(i+1)
//   i        out  WIDTH  step index
//   n        out  WIDTH  current bound
module fib_07_top #(
    parameter int WIDTH  = 11,
    parameter int N_INIT = 20,
    parameter int N_MAX  = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             selector,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] n
);

    localparam logic [WIDTH-1:0] L_N_INIT = WIDTH'(N_INIT);
    localparam logic [WIDTH-1:0] L_N_MAX  = WIDTH'(N_MAX);
    localparam logic [WIDTH-1:0] L_ZERO   = '0;
    localparam logic [WIDTH-1:0] L_ONE    = WIDTH'(1);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_i;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [WIDTH-1:0] w_i_nxt;
    logic [WIDTH-1:0] w_n_nxt;

    // Sum is formed one bit wider so the carry is available for clamping.
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_b_step;
    logic [WIDTH-1:0] w_i_inc;

    assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
    assign w_i_inc = r_i + L_ONE;

`ifdef FIB_SAT_EN
    assign w_b_step = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
    assign w_b_step = w_sum[WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
            r_a     <= L_ZERO;
            r_b     <= L_ONE;
            r_i     <= L_ZERO;
            r_n     <= L_N_INIT;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_i     <= w_i_nxt;
            r_n     <= w_n_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_i_nxt     = r_i;
        w_n_nxt     = r_n;
        case (r_state)
            S_RUN: begin
                if (selector) begin
                    w_a_nxt = r_b;
                    w_b_nxt = w_b_step;
                    w_i_nxt = w_i_inc;
                    // Leave RUN on the same edge as the final step.
                    if (w_i_inc == r_n) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (selector) begin
                    w_a_nxt     = L_ZERO;
                    w_b_nxt     = L_ONE;
                    w_i_nxt     = L_ZERO;
                    w_n_nxt     = (r_n == L_N_MAX) ? L_N_INIT : (r_n + L_ONE);
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    assign a = r_a;
    assign b = r_b;
    assign i = r_i;
    assign n = r_n;

endmodule

// File: tb/tb_fib_07_top.sv
// tb/tb_fib_07_top.sv - scoreboard bench for fib_07_top
module tb_fib_07_top;

    localparam int W    = 11;
    localparam int MODV = 2048;
    localparam int MAXV = 2047;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          selector = 1'b0;
    logic [W-1:0]  a, b, i, n;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int ea;
        int eb;
        int ei;
        int en;
    } exp_t;

    exp_t exp_q[$];

    // reference state: index and bound only; terms are recomputed from scratch
    int m_i = 0;
    int m_n = 20;

    bit mon_prev_valid = 1'b0;

    fib_07_top dut (
        .clk      (clk),
        .rst      (rst),
        .selector (selector),
        .a        (a),
        .b        (b),
        .i        (i),
        .n        (n)
    );

    always #5 clk = ~clk;

    function automatic int fib(input int k);
        int x, y, t;
        x = 0;
        y = 1;
        for (int s = 0; s < k; s++) begin
            t = x + y;
`ifdef FIB_SAT_EN
            if (t > MAXV) t = MAXV;
`else
            t = t % MODV;
`endif
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic chk(input string name, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic chk_now(input string tag, input int ea, input int eb, input int ei, input int en);
        chk({tag, ".a"}, int'(a), ea);
        chk({tag, ".b"}, int'(b), eb);
        chk({tag, ".i"}, int'(i), ei);
        chk({tag, ".n"}, int'(n), en);
    endtask

    // Issue one cycle of stimulus, advance the reference, queue the expectation.
    task automatic apply(input bit sel);
        exp_t e;
        @(negedge clk);
        selector = sel;
        if (sel) begin
            if (m_i < m_n) begin
                m_i = m_i + 1;
            end else begin
                m_i = 0;
                m_n = (m_n == 30) ? 20 : m_n + 1;
            end
        end
        e.ei = m_i;
        e.en = m_n;
        e.ea = fib(m_i);
        e.eb = fib(m_i + 1);
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    // Monitor: pops one expectation per cycle the DUT has been stimulated.
    initial begin : monitor
        exp_t e;
        int   pa, pi;
        pa = 0;
        pi = 0;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb.a", int'(a), e.ea);
                chk("sb.b", int'(b), e.eb);
                chk("sb.i", int'(i), e.ei);
                chk("sb.n", int'(n), e.en);
                chk("inv.i_le_n", int'(i <= n), 1);
                if (mon_prev_valid && int'(i) == pi + 1) begin
`ifdef FIB_SAT_EN
                    chk("inv.b_sum", int'(b), (int'(a) + pa > MAXV) ? MAXV : int'(a) + pa);
`else
                    chk("inv.b_sum", int'(b), (int'(a) + pa) % MODV);
`endif
                end
                pa = int'(a);
                pi = int'(i);
                mon_prev_valid = 1'b1;
            end
        end
    end

    initial begin : stim
        int guard;
        // reset state
        #12;
        chk_now("reset", 0, 1, 0, 20);
        @(negedge clk);
        rst = 1'b1;

        // five steps then three holds
        for (int k = 0; k < 5; k++) apply(1'b1);
        settle();
        chk_now("step5", 5, 8, 5, 20);
        for (int k = 0; k < 3; k++) apply(1'b0);
        settle();
        chk_now("hold3", 5, 8, 5, 20);

        // asynchronous reset mid-cycle, checked before any clock edge
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_now("async_rst", 0, 1, 0, 20);
        m_i = 0;
        m_n = 20;
        mon_prev_valid = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;

        // full run from reset
        for (int k = 0; k < 17; k++) apply(1'b1);
        settle();
`ifdef FIB_SAT_EN
        chk_now("sat17", 1597, 2047, 17, 20);
`else
        chk_now("run17", 1597, 2584 % MODV, 17, 20);
`endif
        for (int k = 0; k < 3; k++) apply(1'b1);
        settle();
`ifdef FIB_SAT_EN
        chk_now("run20", 2047, 2047, 20, 20);
`else
        chk_now("run20", 621, 706, 20, 20);
`endif
        apply(1'b0);
        settle();
        chk_now("done_hold", int'(a), int'(b), 20, 20);
        apply(1'b1);
        settle();
        chk_now("restart", 0, 1, 0, 21);

        // run until parked at n==30, then one restart wraps the bound
        guard = 0;
        while (!(m_n == 30 && m_i == 30) && guard < 2000) begin
            apply(1'b1);
            guard++;
        end
        settle();
        chk_now("park30", int'(a), int'(b), 30, 30);
        apply(1'b1);
        settle();
        chk_now("wrap", 0, 1, 0, 20);

        // random enable
        for (int k = 0; k < 1000; k++) apply(1'($urandom_range(0, 1)));

        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        #5;
        chk("drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
